// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
// The macro ALU_SEQ_FLAGS_EN is consumed by alu_nibble_seq, not by this package.
package alu_seq_pkg;

   localparam int ALU_DATA_W = 32;
   localparam int NIBBLES    = ALU_DATA_W / 4;
   localparam int CNT_W      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   localparam logic [3:0] S_ADD = 4'b1001;
   localparam logic [3:0] S_SUB = 4'b0110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_4bits.sv
// 4-bit '181-style ALU slice: 16 arithmetic functions (M=1) and 16 logic functions (M=0).
module alu_4bits (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic [3:0] i_s,
   input  logic       i_m,
   input  logic       i_ci,
   output logic [3:0] o_f,
   output logic       o_co
);

   logic [3:0] w_x;
   logic [3:0] w_y;
   logic [4:0] w_sum;

   // Every function is X + Y + ci (arithmetic) or ~(X ^ Y) (logic) of these two bitwise terms.
   assign w_x   = i_a | (i_b & {4{i_s[0]}}) | (~i_b & {4{i_s[1]}});
   assign w_y   = (i_a & ~i_b & {4{i_s[2]}}) | (i_a & i_b & {4{i_s[3]}});
   assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, i_ci};

   assign o_f  = i_m ? w_sum[3:0] : ~(w_x ^ w_y);
   assign o_co = i_m ? w_sum[4] : 1'b0;

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial DATA_W-bit ALU built around one shared alu_4bits slice.
// Define ALU_SEQ_FLAGS_EN to add the registered zero_o/neg_o result flags.
module alu_nibble_seq
   import alu_seq_pkg::*;
#(
   parameter int DATA_W  = ALU_DATA_W,
   parameter int SLICE_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              ci_i,
   input  logic [3:0]        S_i,
   input  logic              M_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] s_o,
   output logic              co_o
`ifdef ALU_SEQ_FLAGS_EN
   ,
   output logic              zero_o,
   output logic              neg_o
`endif
);

   localparam int NIB = DATA_W / SLICE_W;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   if (SLICE_W != 4 || (DATA_W % 4) != 0 || DATA_W < 8) begin : g_badParam
      $error("alu_nibble_seq: SLICE_W must be 4 and DATA_W a multiple of 4 (>= 8)");
   end

   state_t              r_state;
   state_t              w_nextState;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [DATA_W-1:0]   r_res;
   logic [3:0]          r_s;
   logic                r_m;
   logic                r_cy;
   logic [CW-1:0]       r_cnt;
   logic                r_finish;
   logic                r_co;
   logic [3:0]          w_f;
   logic                w_co;
   logic                w_sliceCi;

   assign w_sliceCi = r_m ? r_cy : 1'b1;

   alu_4bits u_slice (
      .i_a  (r_a[3:0]),
      .i_b  (r_b[3:0]),
      .i_s  (r_s),
      .i_m  (r_m),
      .i_ci (w_sliceCi),
      .o_f  (w_f),
      .o_co (w_co)
   );

   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_nextState = RUN;
         end
         RUN: begin
            if (r_finish) w_nextState = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // RUN spends NIB cycles shifting nibbles, then one extra cycle to publish carry and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_s      <= '0;
         r_m      <= 1'b0;
         r_cy     <= 1'b0;
         r_cnt    <= '0;
         r_finish <= 1'b0;
         r_co     <= 1'b0;
      end else begin
         r_state <= w_nextState;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a      <= a_i;
                  r_b      <= b_i;
                  r_s      <= S_i;
                  r_m      <= M_i;
                  r_cy     <= M_i ? ci_i : 1'b1;
                  r_cnt    <= '0;
                  r_finish <= 1'b0;
               end
            end
            RUN: begin
               if (!r_finish) begin
                  r_res <= {w_f, r_res[DATA_W-1:SLICE_W]};
                  r_a   <= r_a >> SLICE_W;
                  r_b   <= r_b >> SLICE_W;
                  r_cy  <= w_co;
                  if (r_cnt == CW'(NIB - 1)) begin
                     r_cnt    <= '0;
                     r_finish <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end else begin
                  r_co     <= r_m ? r_cy : 1'b0;
                  r_finish <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign s_o  = r_res;
   assign co_o = r_co;

`ifdef ALU_SEQ_FLAGS_EN
   logic r_zero;
   logic r_neg;

   // Flags are captured from the completed result on the same edge that enters DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero <= 1'b0;
         r_neg  <= 1'b0;
      end else if (r_state == RUN && r_finish) begin
         r_zero <= (r_res == '0);
         r_neg  <= r_res[DATA_W-1];
      end
   end

   assign zero_o = r_zero;
   assign neg_o  = r_neg;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: directed cases plus random operations
// against a full-width function-table model. Honours ALU_SEQ_FLAGS_EN.
module tb_alu_nibble_seq;
   import alu_seq_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        ci_i;
   logic [3:0]  S_i;
   logic        M_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] s_o;
   logic        co_o;
`ifdef ALU_SEQ_FLAGS_EN
   logic        zero_o;
   logic        neg_o;
`endif

   int errCount   = 0;
   int checkCount = 0;

   alu_nibble_seq #(.DATA_W(32), .SLICE_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_i       (a_i),
      .b_i       (b_i),
      .ci_i      (ci_i),
      .S_i       (S_i),
      .M_i       (M_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s_o       (s_o),
      .co_o      (co_o)
`ifdef ALU_SEQ_FLAGS_EN
      ,
      .zero_o    (zero_o),
      .neg_o     (neg_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: simulation still running after 1 ms");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Full-width reference: each function is P + Q + carry (arithmetic) or a plain bitwise op (logic).
   function automatic void refModel(input logic [31:0] a, input logic [31:0] b, input logic ci,
                                    input logic [3:0] s, input logic m,
                                    output logic [31:0] res, output logic co);
      logic [31:0] p;
      logic [31:0] q;
      logic [32:0] sum;
      logic [31:0] ones;
      ones = 32'hFFFF_FFFF;
      res  = '0;
      co   = 1'b0;
      if (!m) begin
         case (s)
            4'h0: res = ~a;
            4'h1: res = ~(a | b);
            4'h2: res = ~a & b;
            4'h3: res = 32'h0;
            4'h4: res = ~(a & b);
            4'h5: res = ~b;
            4'h6: res = a ^ b;
            4'h7: res = a & ~b;
            4'h8: res = ~a | b;
            4'h9: res = ~(a ^ b);
            4'hA: res = b;
            4'hB: res = a & b;
            4'hC: res = ones;
            4'hD: res = a | ~b;
            4'hE: res = a | b;
            default: res = a;
         endcase
      end else begin
         case (s)
            4'h0: begin p = a;      q = 32'h0;   end
            4'h1: begin p = a | b;  q = 32'h0;   end
            4'h2: begin p = a | ~b; q = 32'h0;   end
            4'h3: begin p = ones;   q = 32'h0;   end
            4'h4: begin p = a;      q = a & ~b;  end
            4'h5: begin p = a | b;  q = a & ~b;  end
            4'h6: begin p = a;      q = ~b;      end
            4'h7: begin p = ones;   q = a & ~b;  end
            4'h8: begin p = a;      q = a & b;   end
            4'h9: begin p = a;      q = b;       end
            4'hA: begin p = a | ~b; q = a & b;   end
            4'hB: begin p = ones;   q = a & b;   end
            4'hC: begin p = a;      q = a;       end
            4'hD: begin p = a | b;  q = a;       end
            4'hE: begin p = a | ~b; q = a;       end
            default: begin p = ones; q = a;      end
         endcase
         sum = {1'b0, p} + {1'b0, q} + {32'h0, ci};
         res = sum[31:0];
         co  = sum[32];
      end
   endfunction

   // One full operation: issue, measure latency, check result, hold off for `hold` cycles, release.
   task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic ci, input logic [3:0] s, input logic m, input int hold);
      logic [31:0] expRes;
      logic        expCo;
      int          k;
      refModel(a, b, ci, s, m, expRes, expCo);
      @(negedge clk);
      checkOutput({tag, ".readyIdle"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      a_i = a; b_i = b; ci_i = ci; S_i = s; M_i = m;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a_i = $urandom; b_i = $urandom; ci_i = 1'($urandom); S_i = 4'($urandom); M_i = 1'($urandom);
      checkOutput({tag, ".readyRun"}, 64'(in_ready), 64'd0);
      k = 0;
      while (k < 20) begin
         @(negedge clk);
         k++;
         if (out_valid) break;
      end
      checkOutput({tag, ".latency"}, 64'(k), 64'd9);
      checkOutput({tag, ".s"}, 64'(s_o), 64'(expRes));
      checkOutput({tag, ".co"}, 64'(co_o), 64'(expCo));
`ifdef ALU_SEQ_FLAGS_EN
      checkOutput({tag, ".zero"}, 64'(zero_o), 64'(expRes == 32'h0));
      checkOutput({tag, ".neg"}, 64'(neg_o), 64'(expRes[31]));
`endif
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a_i = $urandom; b_i = $urandom; S_i = 4'($urandom); M_i = 1'($urandom);
         @(negedge clk);
         checkOutput({tag, ".holdValid"}, 64'(out_valid), 64'd1);
         checkOutput({tag, ".holdReady"}, 64'(in_ready), 64'd0);
         checkOutput({tag, ".holdS"}, 64'(s_o), 64'(expRes));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({tag, ".readyAfter"}, 64'(in_ready), 64'd1);
      checkOutput({tag, ".validAfter"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a_i = '0; b_i = '0; ci_i = 1'b0; S_i = '0; M_i = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset.inReady", 64'(in_ready), 64'd1);
      checkOutput("reset.outValid", 64'(out_valid), 64'd0);
      checkOutput("reset.s", 64'(s_o), 64'd0);
      checkOutput("reset.co", 64'(co_o), 64'd0);
`ifdef ALU_SEQ_FLAGS_EN
      checkOutput("reset.zero", 64'(zero_o), 64'd0);
      checkOutput("reset.neg", 64'(neg_o), 64'd0);
`endif
      rst = 1'b0;

      applyStimulus("add",      32'h0000_FFFF, 32'h0000_0001, 1'b0, S_ADD, 1'b1, 0);
      applyStimulus("addWrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, S_ADD, 1'b1, 0);
      applyStimulus("sub",      32'h0000_0005, 32'h0000_0007, 1'b1, S_SUB, 1'b1, 0);
      applyStimulus("xorCi0",   32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b0, 4'b0110, 1'b0, 0);
      applyStimulus("xorCi1",   32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b1, 4'b0110, 1'b0, 0);
      applyStimulus("backpres", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, S_ADD, 1'b1, 5);

      // Reset asserted during RUN discards the operation.
      @(negedge clk);
      in_valid = 1'b1;
      a_i = 32'h7777_7777; b_i = 32'h1111_1111; ci_i = 1'b0; S_i = S_ADD; M_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rstRun.inReady", 64'(in_ready), 64'd1);
      checkOutput("rstRun.outValid", 64'(out_valid), 64'd0);
      repeat (12) @(negedge clk);
      checkOutput("rstRun.noOutput", 64'(out_valid), 64'd0);
      applyStimulus("afterRst", 32'h0000_0001, 32'h0000_0001, 1'b0, S_ADD, 1'b1, 0);

      // Request presented together with reset must not be taken.
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checkOutput("rstValid.inReady", 64'(in_ready), 64'd1);
      repeat (10) @(negedge clk);
      checkOutput("rstValid.noOutput", 64'(out_valid), 64'd0);

      for (int n = 0; n < 40; n++) begin
         applyStimulus("rand", 32'($urandom), 32'($urandom), 1'($urandom), 4'($urandom),
                       1'($urandom), int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Nibble-serial sequencer that performs full DATA_W-bit ALU operations by reusing a single 4-bit ALU slice over DATA_W/4 consecutive cycles. It latches the operands and function select on a valid/ready input handshake and walks the slice from the least-significant nibble upward, chaining carry through a register. It returns the assembled result and carry on a valid/ready output handshake. It sits between the operand issue logic and the result writeback, and trades latency for the area of a full-width ALU.

## Interface
- DATA_W, 32: operand/result width; must be a multiple of 4.
- SLICE_W, 4: slice width; fixed at 4, and any other value is illegal.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operation request.
- in_ready  output  1  sequencer can accept a request.
- a_i, b_i  input  DATA_W  operands.
- ci_i  input  1  carry-in for arithmetic mode.
- S_i  input  4  slice function select.
- M_i  input  1  1 = arithmetic mode, 0 = logic mode.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- s_o  output  DATA_W  result.
- co_o  output  1  final carry-out; 0 in logic mode.
- zero_o, neg_o  output  1 each  result == 0 and result MSB; present only with ALU_SEQ_FLAGS_EN.

## Operation
- State machine has three states: IDLE, RUN and DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid, latch a_i, b_i, S_i and M_i into a_q, b_q, S_q and M_q.
  - Carry register cy_q = M_i ? ci_i : 1.
  - Nibble counter cnt_q = 0, then go to RUN.
- **RUN**
  - The slice is driven with a_q[3:0], b_q[3:0], S_q, M_q and carry-in (M_q ? cy_q : 1).
  - Each cycle, the slice sum nibble shifts into the top of res_q, and a_q and b_q shift right by 4.
  - cy_q takes the slice co, and cnt_q increments.
  - When cnt_q == NIBBLES-1, go to DONE. co_o takes the final slice co if M_q = 1, else 0.
- **DONE**
  - out_valid = 1; s_o = res_q.
  - On out_ready, go to IDLE.
- Logic mode forces the slice carry-in to 1 every nibble, so the result is pure bitwise and independent of ci_i.
- Arithmetic is modulo 2^DATA_W. co_o is the carry out of bit DATA_W-1.
- Inputs are sampled only on the in_valid && in_ready cycle and are ignored otherwise.
- Outputs and flags are stable for the whole of DONE.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - s_o = 0, co_o = 0, zero_o = 0, neg_o = 0.
  - cnt_q = 0, cy_q = 0.
- Latency: a request accepted at edge T produces out_valid = 1 from edge T+1+NIBBLES, i.e. T+9 for DATA_W = 32.
- in_ready is 0 throughout RUN and DONE, and there is no overlap between operations.
- Minimum issue interval is NIBBLES+2 cycles (10 for DATA_W = 32): an output accepted at edge U returns in_ready = 1 after U.
- out_valid is held indefinitely while out_ready = 0.
- rst asserted in any state returns to IDLE at the next edge and discards the in-flight operation; no output is produced for it.
- A simultaneous rst and in_valid does not accept the request.

## Configuration
- ALU_SEQ_FLAGS_EN defined:
  - zero_o and neg_o ports exist.
  - They are registered on entry to DONE from the final res_q, and held through DONE.
  - They reset to 0.
- ALU_SEQ_FLAGS_EN undefined: the ports and their logic are absent, and all other behaviour is identical.

## Structure
- Package alu_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparam NIBBLES = DATA_W/4;
  - counter width $clog2(NIBBLES);
  - named S_i encodings: S_ADD = 4'b1001, S_SUB = 4'b0110.
- One sub-module: a single alu_4bits instance as the shared slice. The sequencer owns all registers around it.

## Test plan
- **Add:** a=0x0000_FFFF, b=0x0000_0001, ci=0, S=1001, M=1.
  - Expect s_o=0x0001_0000, co_o=0.
  - out_valid asserts exactly 9 cycles after acceptance.
- **Add wrap:** a=0xFFFF_FFFF, b=0x0000_0001, ci=0, S=1001, M=1.
  - Expect s_o=0x0000_0000, co_o=1.
  - Expect zero_o=1 when flags are enabled.
- **Subtract:** a=5, b=7, ci=1, S=0110, M=1.
  - Expect s_o=0xFFFF_FFFE, co_o=0 (borrow).
  - Expect neg_o=1 when flags are enabled.
- **Logic XOR:** a=0xA5A5_A5A5, b=0x0F0F_0F0F, S=0110, M=0, run with ci=0 and again with ci=1.
  - Expect s_o=0xAAAA_AAAA and co_o=0 in both runs.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - s_o and out_valid stay stable, in_ready=0, and the new request is not accepted.
  - After out_ready, in_ready=1 the next cycle.
- **Reset mid-operation:** assert rst at RUN cycle 4.
  - Next cycle: in_ready=1, out_valid=0.
  - A following add of 1+1 completes with s_o=2.
